// File: rtl/sram_pkg.sv
// Shared constants and FSM state type for the SRAM stream reader.
`default_nettype none

package sram_pkg;
  localparam int SRAM_DEPTH = 1728;
  localparam int SRAM_AW    = 11;
  localparam int SRAM_DW    = 99;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } state_t;
endpackage

`default_nettype wire

// File: rtl/stream_fifo2.sv
// Two-entry FIFO that exposes its occupancy; head is visible whenever count != 0.
`default_nettype none

module stream_fifo2
  import sram_pkg::*;
#(
  parameter int DW = SRAM_DW
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          push,
  input  logic [DW-1:0] push_data,
  input  logic          pop,
  output logic [DW-1:0] head,
  output logic [1:0]    count
);

  logic [DW-1:0] mem [2];
  logic          wr_ptr;
  logic          rd_ptr;

  always_ff @(posedge clk) begin
    if (rst) begin
      mem[0] <= '0;
      mem[1] <= '0;
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      count  <= 2'd0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= push_data;
        wr_ptr      <= ~wr_ptr;
      end
      if (pop) begin
        rd_ptr <= ~rd_ptr;
      end
      count <= count + {1'b0, push} - {1'b0, pop};
    end
  end

  assign head = mem[rd_ptr];

endmodule

`default_nettype wire

// File: rtl/sram_stream_reader.sv
// Burst read initiator for the single-port SRAM macro: issues reads and streams
// the returned words out on a valid/ready interface through a 2-entry skid FIFO.
`default_nettype none

module sram_stream_reader
  import sram_pkg::*;
#(
  parameter int DEPTH = SRAM_DEPTH,
  parameter int AW    = SRAM_AW,
  parameter int DW    = SRAM_DW
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic [AW-1:0] base_addr,
  input  logic [AW-1:0] length,
  output logic          busy,
  output logic          done,
  output logic          sram_csb,
  output logic          sram_wsb,
  output logic [AW-1:0] sram_raddr,
  output logic [AW-1:0] sram_waddr,
  output logic [DW-1:0] sram_wdata,
  input  logic [DW-1:0] sram_rdata,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [DW-1:0] out_data
);

  state_t        state, state_next;
  logic [AW-1:0] addr;
  logic [AW-1:0] issue_left;
  logic [AW-1:0] deliver_left;
  logic [1:0]    fifo_count;
  logic [DW-1:0] fifo_head;
  logic          rd_pending;
  logic          handshake;

  // rd_pending marks a read issued this cycle; its data is valid at the
  // closing posedge, so it doubles as the FIFO push. Only registered state
  // feeds it, keeping csb independent of out_ready.
  always_comb begin
    rd_pending = (state == ST_RUN) && (issue_left != '0) && (fifo_count <= 2'd1);
    out_valid  = (fifo_count != 2'd0);
    handshake  = out_valid && out_ready;
    state_next = state;
    case (state)
      ST_IDLE: begin
        if (start) state_next = (length == '0) ? ST_DONE : ST_RUN;
      end
      ST_RUN: begin
        if (rd_pending && (issue_left == AW'(1))) state_next = ST_DRAIN;
      end
      ST_DRAIN: begin
        if ((deliver_left == '0) || ((deliver_left == AW'(1)) && handshake))
          state_next = ST_DONE;
      end
      default: state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= ST_IDLE;
      addr         <= '0;
      issue_left   <= '0;
      deliver_left <= '0;
    end else begin
      state <= state_next;
      if ((state == ST_IDLE) && start) begin
        addr         <= base_addr;
        issue_left   <= length;
        deliver_left <= length;
      end else begin
        if (rd_pending) begin
          addr       <= (addr == AW'(DEPTH - 1)) ? '0 : addr + AW'(1);
          issue_left <= issue_left - AW'(1);
        end
        if (handshake) deliver_left <= deliver_left - AW'(1);
      end
    end
  end

  stream_fifo2 #(.DW(DW)) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (rd_pending),
    .push_data (sram_rdata),
    .pop       (handshake),
    .head      (fifo_head),
    .count     (fifo_count)
  );

  assign busy       = (state == ST_RUN) || (state == ST_DRAIN);
  assign done       = (state == ST_DONE);
  assign sram_csb   = ~rd_pending;
  assign sram_wsb   = 1'b1;
  assign sram_raddr = addr;
  assign sram_waddr = '0;
  assign sram_wdata = '0;
  assign out_data   = fifo_head;

endmodule

`default_nettype wire

// File: tb/tb_sram_stream_reader.sv
// Randomized/directed bench for sram_stream_reader with an SRAM memory model and
// a burst-level reference (address sequence, occupancy, delivery order, timing).
`default_nettype none

module tb_sram_stream_reader;
  localparam int DEPTH = 1728;
  localparam int AW    = 11;
  localparam int DW    = 99;

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic [AW-1:0] base_addr;
  logic [AW-1:0] length;
  logic          busy, done;
  logic          sram_csb, sram_wsb;
  logic [AW-1:0] sram_raddr, sram_waddr;
  logic [DW-1:0] sram_wdata;
  logic [DW-1:0] sram_rdata = '0;
  logic          out_valid;
  logic          out_ready;
  logic [DW-1:0] out_data;

  logic [DW-1:0] mem [DEPTH];
  int tests = 0;
  int fails = 0;

  sram_stream_reader dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .base_addr  (base_addr),
    .length     (length),
    .busy       (busy),
    .done       (done),
    .sram_csb   (sram_csb),
    .sram_wsb   (sram_wsb),
    .sram_raddr (sram_raddr),
    .sram_waddr (sram_waddr),
    .sram_wdata (sram_wdata),
    .sram_rdata (sram_rdata),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_data   (out_data)
  );

  always #5 clk = ~clk;

  // SRAM macro: samples on the falling edge, holds stale data while deselected.
  always @(negedge clk) begin
    if (!sram_csb) sram_rdata <= mem[sram_raddr];
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    tests++;
    assert (got === exp)
    else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_busy"}, busy, 1'b0);
    check({tag, "_done"}, done, 1'b0);
    check({tag, "_csb"}, sram_csb, 1'b1);
    check({tag, "_raddr"}, sram_raddr, '0);
    check({tag, "_valid"}, out_valid, 1'b0);
    check({tag, "_data"}, out_data, '0);
  endtask

  task automatic fill_random();
    logic [127:0] r;
    for (int i = 0; i < DEPTH; i++) begin
      r = {$urandom, $urandom, $urandom, $urandom};
      mem[i] = r[DW-1:0];
    end
  endtask

  // mode 0: ready always 1; mode 1: ready pattern 1,0,0,...; mode 2: random ready.
  // hijack_c > 0 pulses a conflicting start in that cycle of the burst.
  task automatic run_burst(input int base, input int len, input int mode, input int hijack_c);
    int  issued, delivered, occ, done_c, first_issue_c;
    bit  rdy, hs, iss;
    start     = 1'b1;
    base_addr = AW'(base);
    length    = AW'(len);
    tick();
    start = 1'b0;
    issued = 0; delivered = 0; occ = 0; done_c = 0; first_issue_c = 0;
    for (int c = 1; c <= len * 4 + 20 && done_c == 0; c++) begin
      rdy = (mode == 0) ? 1'b1 : (mode == 1) ? (c % 3 == 1) : 1'($urandom % 2);
      out_ready = rdy;
      if (hijack_c > 0 && c == hijack_c) begin
        start     = 1'b1;
        base_addr = AW'((base + 100) % DEPTH);
        length    = AW'(3);
      end else begin
        start = 1'b0;
      end
      iss = !sram_csb;
      check("valid_vs_occupancy", out_valid, occ > 0);
      if (iss) begin
        if (first_issue_c == 0) first_issue_c = c;
        check("raddr", sram_raddr, (base + issued) % DEPTH);
        check("no_issue_when_occ_gt1", occ <= 1, 1'b1);
        issued++;
      end
      hs = out_valid && rdy;
      if (hs) begin
        check("out_data", out_data, mem[(base + delivered) % DEPTH]);
        delivered++;
      end
      check("busy", busy, (len != 0) && !done);
      if (done) begin
        done_c = c;
        check("delivered_at_done", delivered, len);
      end
      occ = occ + int'(iss) - int'(hs);
      check("occupancy_max2", occ <= 2, 1'b1);
      tick();
    end
    start = 1'b0;
    check("done_seen", done_c != 0, 1'b1);
    check("issue_count", issued, len);
    if (mode == 0) begin
      check("done_cycle", done_c, (len == 0) ? 1 : len + 2);
      if (len > 0) check("first_issue_cycle", first_issue_c, 1);
    end
    check("done_one_cycle", done, 1'b0);
    check("idle_busy", busy, 1'b0);
    check("idle_csb", sram_csb, 1'b1);
    check("idle_valid", out_valid, 1'b0);
    tick();
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; base_addr = '0; length = '0; out_ready = 1'b0;
    for (int i = 0; i < DEPTH; i++) mem[i] = DW'(i);
    tick(); tick(); tick();
    check_reset_outputs("reset");
    rst = 1'b0;
    tick();

    run_burst(5, 4, 0, 0);
    fill_random();
    run_burst(1726, 4, 0, 0);
    run_burst(10, 8, 1, 0);
    run_burst(300, 0, 0, 0);

    // Reset in the middle of a burst: abandon it, then run a fresh one.
    start = 1'b1; base_addr = AW'(50); length = AW'(10); out_ready = 1'b1;
    tick();
    start = 1'b0;
    for (int c = 1; c < 5; c++) tick();
    rst = 1'b1;
    tick();
    check_reset_outputs("midburst_reset");
    rst = 1'b0;
    for (int c = 0; c < 4; c++) begin
      check("post_reset_no_done", done, 1'b0);
      check("post_reset_csb", sram_csb, 1'b1);
      tick();
    end
    run_burst(0, 2, 0, 0);

    run_burst(20, 8, 0, 3);
    run_burst(900, 8, 2, 2);
    for (int k = 0; k < 6; k++)
      run_burst(int'($urandom_range(0, DEPTH - 1)), int'($urandom_range(0, 24)),
                int'($urandom_range(0, 2)), 0);
    run_burst(7, DEPTH, 0, 0);

    check("wsb_tied", sram_wsb, 1'b1);
    check("waddr_tied", sram_waddr, '0);
    check("wdata_tied", sram_wdata, '0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

`default_nettype wire
